// File: rtl/keypad_scan_sequencer_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scan sequencer.
package keypad_pkg;

  typedef enum logic [2:0] {
    SETTLE   = 3'd0,
    SAMPLE   = 3'd1,
    DEBOUNCE = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] ROW_ONEHOT_N [NUM_ROWS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } single_low_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic single_low_t single_low(input logic [3:0] col);
    single_low_t res;
    case (col)
      4'b1110: res = '{valid: 1'b1, idx: 2'd0};
      4'b1101: res = '{valid: 1'b1, idx: 2'd1};
      4'b1011: res = '{valid: 1'b1, idx: 2'd2};
      4'b0111: res = '{valid: 1'b1, idx: 2'd3};
      default: res = '{valid: 1'b0, idx: 2'd0};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_sequencer_col_sync.sv
// Two-flop synchronizer for asynchronous active-low column inputs; resets to all ones (idle).
module col_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b1}};
      q      <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// Sequenced 4x4 keypad scanner: row drive, settle, sample, press/release debounce, key events.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_sequencer
  import keypad_pkg::*;
#(
  parameter int ROW_SETTLE_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES      = 60000,
  parameter int REPEAT_DELAY_CYCLES  = 1500000,
  parameter int REPEAT_PERIOD_CYCLES = 300000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] keypad_rows,
  input  logic [3:0] keypad_cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  // One counter width covers every configured interval so all counters share sat_inc.
  localparam int CNT_MAX = max_int(max_int(ROW_SETTLE_CYCLES, DEBOUNCE_CYCLES),
                                   max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(ROW_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) r = v;
    else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  scan_state_t      state_r;
  logic [1:0]       row_idx_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       col_pat_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       col_sync_s;
  single_low_t      press_s;
  logic [1:0]       next_row_s;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
  logic [CNT_W-1:0] rpt_cnt_r;
  logic             rpt_first_r;
`endif

  col_sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (keypad_cols),
    .q     (col_sync_s)
  );

  assign press_s    = single_low(col_sync_s);
  assign next_row_s = row_idx_r + 2'd1;

  // Scan/debounce FSM with registered row drive and key outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= SETTLE;
      row_idx_r   <= 2'd0;
      col_idx_r   <= 2'd0;
      col_pat_r   <= 4'hF;
      cnt_r       <= CNT_ZERO;
      keypad_rows <= ROW_ONEHOT_N[0];
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      key_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_r   <= CNT_ZERO;
      rpt_first_r <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state_r)
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= SAMPLE;
          end else begin
            cnt_r <= sat_inc(cnt_r);
          end
        end
        SAMPLE: begin
          if (press_s.valid) begin
            col_pat_r <= col_sync_s;
            col_idx_r <= press_s.idx;
            cnt_r     <= CNT_ZERO;
            state_r   <= DEBOUNCE;
          end else begin
            row_idx_r   <= next_row_s;
            keypad_rows <= ROW_ONEHOT_N[next_row_s];
            cnt_r       <= CNT_ZERO;
            state_r     <= SETTLE;
          end
        end
        DEBOUNCE: begin
          if (col_sync_s != col_pat_r) begin
            row_idx_r   <= next_row_s;
            keypad_rows <= ROW_ONEHOT_N[next_row_s];
            cnt_r       <= CNT_ZERO;
            state_r     <= SETTLE;
          end else if (cnt_r == DEBOUNCE_LAST) begin
            key_code  <= key_lookup(row_idx_r, col_idx_r);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= HELD;
`ifdef KEY_REPEAT_EN
            rpt_cnt_r   <= CNT_ZERO;
            rpt_first_r <= 1'b1;
`endif
          end else begin
            cnt_r <= sat_inc(cnt_r);
          end
        end
        HELD: begin
          // Only the latched column is watched, so other keys are invisible here.
          if (col_sync_s[col_idx_r]) begin
            cnt_r   <= CNT_ZERO;
            state_r <= RELEASE;
`ifdef KEY_REPEAT_EN
            rpt_cnt_r <= CNT_ZERO;
`endif
          end else begin
`ifdef KEY_REPEAT_EN
            if (rpt_cnt_r == (rpt_first_r ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
              key_valid   <= 1'b1;
              rpt_cnt_r   <= CNT_ZERO;
              rpt_first_r <= 1'b0;
            end else begin
              rpt_cnt_r <= sat_inc(rpt_cnt_r);
            end
`else
            cnt_r <= CNT_ZERO;
`endif
          end
        end
        RELEASE: begin
          if (!col_sync_s[col_idx_r]) begin
            state_r <= HELD;
          end else if (cnt_r == DEBOUNCE_LAST) begin
            key_held    <= 1'b0;
            row_idx_r   <= next_row_s;
            keypad_rows <= ROW_ONEHOT_N[next_row_s];
            cnt_r       <= CNT_ZERO;
            state_r     <= SETTLE;
          end else begin
            cnt_r <= sat_inc(cnt_r);
          end
        end
        default: begin
          state_r     <= SETTLE;
          row_idx_r   <= 2'd0;
          keypad_rows <= ROW_ONEHOT_N[0];
          cnt_r       <= CNT_ZERO;
          key_held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_scan_sequencer.md
Name: keypad_scan_sequencer

Overview:
Controller that sequences the 4x4 keypad scan datapath.
- Drives rows one at a time (active-low) and waits a settle time before sampling the synchronized columns.
- Debounces both press and release.
- Emits exactly one key event per press, plus a held status.
- Sits between the keypad pins and keypad_controller, replacing the separate scanner, decoder and debouncer chain with one sequenced FSM.

Parameters:
ROW_SETTLE_CYCLES, 8, cycles each row is driven before columns are sampled (>=1)
DEBOUNCE_CYCLES, 60000, consecutive stable cycles required to accept a press or release (20 ms at 3 MHz, >=2)
REPEAT_DELAY_CYCLES, 1500000, first auto-repeat delay after accepted press (used only with KEY_REPEAT_EN)
REPEAT_PERIOD_CYCLES, 300000, auto-repeat interval (used only with KEY_REPEAT_EN)

Ports:
clk  input  1  system clock, 3 MHz
reset  input  1  asynchronous, active-high reset
keypad_rows  output  4  row drive, active-low one-hot
keypad_cols  input  4  raw column inputs, active-low, asynchronous to clk
key_valid  output  1  one-cycle pulse: new accepted key
key_code  output  4  hex code of accepted key, held stable until next accepted key
key_held  output  1  high while an accepted key remains pressed, including during release debounce

Behaviour:
Reset values (asynchronous):
- keypad_rows=4'b1110 (row 0), key_valid=0, key_code=4'h0, key_held=0.
- State SETTLE, row index 0, all counters 0, synchronizer flops 4'b1111.

Column sampling:
- keypad_cols pass through a 2-flop synchronizer; the FSM sees only col_sync.
- A "single press" is col_sync with exactly one bit low. Multiple low bits count as no key.

States:
- SETTLE: drive the current row; count to ROW_SETTLE_CYCLES-1, then go to SAMPLE.
- SAMPLE, 1 cycle:
  - Single press: latch row index and column pattern, clear counter, go to DEBOUNCE.
  - Otherwise: advance row index (3 wraps to 0), update keypad_rows on the same edge, go to SETTLE.
- DEBOUNCE: row frozen.
  - col_sync equals latched pattern: counter increments.
  - Any mismatch: abandon, advance row, go to SETTLE, no event.
  - Counter reaches DEBOUNCE_CYCLES-1 with match: on the next edge set key_code from the lookup, pulse key_valid for 1 cycle, set key_held=1, go to HELD.
- HELD: row frozen; only the latched column bit is monitored. When that bit reads 1, clear counter and go to RELEASE.
- RELEASE:
  - Latched bit reads 0 again: return to HELD with no new event.
  - Bit stays 1 for DEBOUNCE_CYCLES cycles: key_held=0, advance row, go to SETTLE.

Key map (row, col0..col3):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D

Latency: a stable press reaches key_valid 2 (sync) + 1 (SAMPLE) + DEBOUNCE_CYCLES + 1 cycles after the column edge, provided the key's row is already in SAMPLE.

Boundary rules:
- A second key pressed while HELD is ignored, including keys in other rows. After release, scanning resumes from the next row.
- Keys held through reset: normal scanning restarts and the key is re-reported after debounce.
- Reset mid-DEBOUNCE: no event emitted.
- Counters saturate and never wrap.

Optional Feature:
KEY_REPEAT_EN
- Defined: in HELD, after REPEAT_DELAY_CYCLES, key_valid re-pulses with the same key_code every REPEAT_PERIOD_CYCLES until release is detected. The repeat counter clears on entering RELEASE and is not reset on a RELEASE-to-HELD bounce.
- Undefined: repeat counters and parameters are unused, and exactly one pulse is emitted per press.

Decomposition:
- Package keypad_pkg:
  - scan_state_t enum (SETTLE, SAMPLE, DEBOUNCE, HELD, RELEASE)
  - NUM_ROWS=4, NUM_COLS=4
  - ROW_ONEHOT_N constant array
  - function key_lookup(row_idx, col_idx) returning 4-bit code
  - function single_low(col) returning valid flag and index
- Sub-module: col_sync_2ff (parameterized width, reset value 1s) for the synchronizer.

Test Plan:
All scenarios use ROW_SETTLE_CYCLES=2 and DEBOUNCE_CYCLES=4 unless noted.
1. Release reset, no keys -> keypad_rows cycles 1110, 1101, 1011, 0111, 1110, each held 3 cycles; key_valid never asserts; key_held=0.
2. Hold keypad_cols=4'b1011 only while keypad_rows=1101 (row1, col2) -> one key_valid pulse with key_code=4'h6; key_held=1; keypad_rows frozen at 1101. After release plus 4 cycles -> key_held=0 and scanning resumes at 1011.
3. Press row0/col0 with a glitch (1110 for 2 cycles, then 1111, then 1110) -> no pulse on the glitch; a stable press then yields key_code=4'h1 once.
4. Hold 'D' (row3, col3), press '5' (row1, col1), bounce the 'D' release for 2 cycles, then release both -> exactly one pulse (4'hD); '5' is reported only after scanning reaches row1 again.
5. keypad_cols=4'b1010 during row2 -> no pulse; scanning continues. Separately, assert reset mid-DEBOUNCE -> keypad_rows=1110 immediately with no pulse.
6. With KEY_REPEAT_EN, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5, hold '0' for 30 cycles -> pulses at accept, +10, +15, +20, +25, all with key_code=4'h0; without the macro -> a single pulse.
